// File: rtl/noc_pkg.sv
// Shared NoC definitions for the spine tier.
// Flit layout: [15:10] routing address, [9:0] payload.
// The destination leaf is carried in bits [5:2] of the routing address.
package noc_pkg;
    localparam int FLIT_W     = 16;
    localparam int ADDR_W     = 6;
    localparam int ROUTE_HI   = 15;
    localparam int ROUTE_LO   = 10;
    localparam int PAYLOAD_W  = 10;
    localparam int LEAF_ID_HI = 5;
    localparam int LEAF_ID_LO = 2;
    localparam int LEAF_ID_W  = LEAF_ID_HI - LEAF_ID_LO + 1;

    typedef struct packed {
        logic [ROUTE_HI-ROUTE_LO:0] route;
        logic [PAYLOAD_W-1:0]       payload;
    } flit_t;

    // Destination leaf index carried in a routing address.
    function automatic logic [LEAF_ID_W-1:0] leaf_id(input logic [ADDR_W-1:0] addr);
        return addr[LEAF_ID_HI:LEAF_ID_LO];
    endfunction
endpackage

// File: rtl/spine_in_fifo.sv
// Per-input synchronous FIFO for the spine switch.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   push_i, din_i   write strobe / entry (ignored when full)
//   pop_i           read strobe (ignored when empty)
//   full_o          registered-count full flag
//   empty_o         no entry visible to the reader
//   head_o          oldest visible entry
// A written entry becomes visible to the reader one cycle after the write,
// which registers the request path between the input port and the arbiters.
module spine_in_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_q, rd_q, wr_vis_q;
    logic        do_push, do_pop;

    assign full_o  = ((wr_q - rd_q) == (AW+1)'(DEPTH));
    assign empty_o = (wr_vis_q == rd_q);
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q     <= '0;
            rd_q     <= '0;
            wr_vis_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            wr_vis_q <= wr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/spine_switch.sv
// Spine-tier crossbar: NUM_LEAF leaf inputs, each buffered in a FIFO, routed
// by dest_addr[5:2] to NUM_LEAF registered outputs with per-output
// round-robin arbitration.
// Ports:
//   ACLK, ARESETn                clock, async active-low reset
//   leaf_in_data/valid/dest_addr flit, valid, route sideband from leaf i
//   leaf_in_ready                input FIFO i not full
//   leaf_out_data/valid/dest_addr flit, valid, route sideband to leaf j
//   leaf_out_ready               leaf j accepts a flit
//   err_bad_dest                 pulse when head of input i is dropped
// Optional (macro SPINE_STATS_EN):
//   stat_fwd_cnt   per-output completed handshakes, saturating 16 bit
//   stat_drop_cnt  total invalid-destination drops, saturating 16 bit
module spine_switch #(
    parameter int NUM_LEAF   = 4,
    parameter int FLIT_W     = noc_pkg::FLIT_W,
    parameter int ADDR_W     = noc_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [NUM_LEAF*FLIT_W-1:0] leaf_in_data,
    input  logic [NUM_LEAF-1:0]        leaf_in_valid,
    input  logic [NUM_LEAF*ADDR_W-1:0] leaf_in_dest_addr,
    output logic [NUM_LEAF-1:0]        leaf_in_ready,
    output logic [NUM_LEAF*FLIT_W-1:0] leaf_out_data,
    output logic [NUM_LEAF-1:0]        leaf_out_valid,
    output logic [NUM_LEAF*ADDR_W-1:0] leaf_out_dest_addr,
    input  logic [NUM_LEAF-1:0]        leaf_out_ready,
    output logic [NUM_LEAF-1:0]        err_bad_dest
`ifdef SPINE_STATS_EN
    ,
    output logic [NUM_LEAF*16-1:0]     stat_fwd_cnt,
    output logic [15:0]                stat_drop_cnt
`endif
);
    import noc_pkg::*;

    localparam int IW = (NUM_LEAF > 1) ? $clog2(NUM_LEAF) : 1;
    localparam int EW = ADDR_W + FLIT_W;

    // Reset deasserts synchronously: everything downstream resets on rst_q,
    // which drops with ARESETn and rises on the first edge after release.
    logic rst_q;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rst_q <= 1'b0;
        else          rst_q <= 1'b1;
    end

    logic [NUM_LEAF-1:0]                push, pop, full, empty, bad;
    logic [NUM_LEAF-1:0][EW-1:0]        hd;
    logic [NUM_LEAF-1:0][FLIT_W-1:0]    hd_data;
    logic [NUM_LEAF-1:0][ADDR_W-1:0]    hd_dest;
    logic [NUM_LEAF-1:0][LEAF_ID_W-1:0] hd_leaf;
    logic [NUM_LEAF-1:0][NUM_LEAF-1:0]  req;     // [output][input]

    logic [NUM_LEAF-1:0]                out_vld_q, out_free, gnt_vld;
    logic [NUM_LEAF-1:0][FLIT_W-1:0]    out_data_q;
    logic [NUM_LEAF-1:0][ADDR_W-1:0]    out_dest_q;
    logic [NUM_LEAF-1:0][IW-1:0]        rr_q, gnt_idx;

    function automatic logic [IW-1:0] rr_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_LEAF) s = s - NUM_LEAF;
        return IW'(s);
    endfunction

    for (genvar i = 0; i < NUM_LEAF; i++) begin : g_in
        assign leaf_in_ready[i] = rst_q & ~full[i];
        assign push[i]          = leaf_in_valid[i] & leaf_in_ready[i];

        spine_in_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i  (ACLK),
            .rst_ni (rst_q),
            .push_i (push[i]),
            .din_i  ({leaf_in_dest_addr[i*ADDR_W +: ADDR_W], leaf_in_data[i*FLIT_W +: FLIT_W]}),
            .pop_i  (pop[i]),
            .full_o (full[i]),
            .empty_o(empty[i]),
            .head_o (hd[i])
        );

        assign {hd_dest[i], hd_data[i]} = hd[i];
        assign hd_leaf[i] = leaf_id(hd_dest[i]);
        // Out-of-range heads are discarded; they never raise a request.
        assign bad[i]     = ~empty[i] && (int'(hd_leaf[i]) >= NUM_LEAF);
    end

    for (genvar j = 0; j < NUM_LEAF; j++) begin : g_req
        for (genvar i = 0; i < NUM_LEAF; i++) begin : g_src
            assign req[j][i] = ~empty[i] && (int'(hd_leaf[i]) == j);
        end
    end

    assign err_bad_dest = bad;

    // Each head decodes to one output, so grants across outputs never collide
    // on an input and pop can be the OR of all grants plus drops.
    always_comb begin
        gnt_vld  = '0;
        gnt_idx  = '0;
        pop      = bad;
        out_free = ~out_vld_q | leaf_out_ready;
        for (int j = 0; j < NUM_LEAF; j++) begin
            for (int k = 0; k < NUM_LEAF; k++) begin
                if (out_free[j] && !gnt_vld[j] && req[j][rr_add(rr_q[j], k)]) begin
                    gnt_vld[j] = 1'b1;
                    gnt_idx[j] = rr_add(rr_q[j], k);
                end
            end
            if (gnt_vld[j]) pop[gnt_idx[j]] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge rst_q) begin
        if (!rst_q) begin
            out_vld_q  <= '0;
            out_data_q <= '0;
            out_dest_q <= '0;
            rr_q       <= '0;
        end else begin
            for (int j = 0; j < NUM_LEAF; j++) begin
                if (gnt_vld[j]) begin
                    out_vld_q[j]  <= 1'b1;
                    out_data_q[j] <= hd_data[gnt_idx[j]];
                    out_dest_q[j] <= hd_dest[gnt_idx[j]];
                    rr_q[j]       <= rr_add(gnt_idx[j], 1);
                end else if (leaf_out_ready[j]) begin
                    out_vld_q[j]  <= 1'b0;
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_LEAF; j++) begin : g_out
        assign leaf_out_data[j*FLIT_W +: FLIT_W]      = out_data_q[j];
        assign leaf_out_dest_addr[j*ADDR_W +: ADDR_W] = out_dest_q[j];
    end
    assign leaf_out_valid = out_vld_q;

`ifdef SPINE_STATS_EN
    logic [NUM_LEAF-1:0][15:0] fwd_cnt_q;
    logic [15:0]               drop_cnt_q;
    logic [16:0]               drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(bad));

    always_ff @(posedge ACLK or negedge rst_q) begin
        if (!rst_q) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int j = 0; j < NUM_LEAF; j++) begin
                if (out_vld_q[j] && leaf_out_ready[j] && fwd_cnt_q[j] != 16'hFFFF)
                    fwd_cnt_q[j] <= fwd_cnt_q[j] + 16'd1;
            end
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    for (genvar j = 0; j < NUM_LEAF; j++) begin : g_stat
        assign stat_fwd_cnt[j*16 +: 16] = fwd_cnt_q[j];
    end
    assign stat_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: doc/spine_switch.md
Name: spine_switch

Overview:
- Spine-tier crossbar at the far end of the leaf router's four spine uplinks.
- Accepts 16-bit flits from NUM_LEAF leaf routers and buffers each input in a FIFO.
- Decodes the destination leaf from routing address bits [5:2] and round-robin arbitrates each downlink.
- Forwards each flit unmodified to the destination leaf's spine input.

Parameters:
- NUM_LEAF, 4, number of leaf ports, 2..8.
- FLIT_W, 16, flit width; [15:10] routing address, [9:0] payload.
- ADDR_W, 6, width of the routing address / dest_addr sideband.
- FIFO_DEPTH, 4, entries per input FIFO; power of two, at least 2.

Ports:
- ACLK  input  1  clock.
- ARESETn  input  1  asynchronous active-low reset.
- leaf_in_data  input  NUM_LEAF*FLIT_W  flit from leaf i, slice i.
- leaf_in_valid  input  NUM_LEAF  flit valid per leaf.
- leaf_in_dest_addr  input  NUM_LEAF*ADDR_W  routing address sideband per leaf.
- leaf_in_ready  output  NUM_LEAF  input FIFO i not full.
- leaf_out_data  output  NUM_LEAF*FLIT_W  flit to leaf j.
- leaf_out_valid  output  NUM_LEAF  output register j holds a flit.
- leaf_out_dest_addr  output  NUM_LEAF*ADDR_W  routing address sideband to leaf j.
- leaf_out_ready  input  NUM_LEAF  leaf j accepts a flit.
- err_bad_dest  output  NUM_LEAF  one-cycle pulse: head of input i dropped for an invalid destination.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - all FIFOs empty; leaf_in_ready=all 1s one cycle after deassert, 0 while ARESETn=0.
  - leaf_out_valid=0, leaf_out_data=0, leaf_out_dest_addr=0, err_bad_dest=0.
  - round-robin pointers=0.
- Input handshake: transfer when leaf_in_valid[i]&&leaf_in_ready[i] at a posedge. The FIFO stores {dest_addr, data}.
- Sideband: dest_addr is the authoritative route key; data[15:10] is passed through unchecked.
- Destination decode: dest leaf = dest_addr[5:2].
  - If dest leaf >= NUM_LEAF, the head is popped without forwarding and err_bad_dest[i] pulses in the same cycle as the pop.
- Hairpin allowed: input i may target output i.
- Per-output arbitration:
  - Output j is free when !leaf_out_valid[j] || leaf_out_ready[j].
  - When free, output j grants the first requesting head scanning round-robin from rr_ptr[j]. rr_ptr[j] then moves to grant+1 mod NUM_LEAF.
  - No grant leaves rr_ptr unchanged.
  - Each input targets at most one output, so each input gets at most one grant per cycle.
- Output register: a granted head loads into output j and pops at the same edge. valid is held with data stable until leaf_out_ready[j].
  - A simultaneous drain and reload gives full throughput: 1 flit/cycle/output.
- Latency: a flit accepted at edge k appears with leaf_out_valid=1 after edge k+2 when uncontended. There is no bypass.
- FIFO full: leaf_in_ready[i]=0. Simultaneous pop and push when full is not accepted; ready is registered from the count.
- FIFO empty: no request.
- Pointer wrap: pointers are modulo FIFO_DEPTH.
- Ordering: flits from one input to one output leave in arrival order.
- Fairness: with N inputs contending, every input is served within N grants.
- Reset mid-operation: all buffered flits are discarded. No partial output is held.

Optional Feature:
- Macro: SPINE_STATS_EN.
- Defined:
  - adds output stat_fwd_cnt, NUM_LEAF*16: per-output count of completed out handshakes.
  - adds output stat_drop_cnt, 16: total invalid-destination drops.
  - both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W, ADDR_W, ROUTE_HI=15, ROUTE_LO=10, PAYLOAD_W=10.
  - LEAF_ID_HI=5, LEAF_ID_LO=2.
  - a flit struct typedef {route, payload}.
- Sub-module spine_in_fifo, one per input: synchronous FIFO with push/pop/full/empty/head.
- Arbitration and output registers stay in spine_switch.

Test Plan:
- Single flit: leaf 0 sends data=16'h12AB, dest=6'b000100 -> leaf_out_valid[1]=1 two cycles later with data 16'h12AB; no other output valid.
- Contention: leaves 0,2,3 each send to leaf 1 every cycle, out_ready=1 -> outputs in grant order 0,2,3,0,2,3; 1 flit/cycle; no loss.
- Backpressure: leaf_out_ready[2]=0 while leaf 1 streams 6 flits to leaf 2 (FIFO_DEPTH=4):
  - leaf_in_ready[1] drops after 5 accepted (4 FIFO + 1 out reg).
  - releasing ready delivers all 6 in order.
- Bad destination: dest=6'b010000 with NUM_LEAF=4 -> err_bad_dest pulses once; no output valid.
  - With SPINE_STATS_EN, stat_drop_cnt=1.
- Parallel paths: 0->3, 1->2, 2->1, 3->0 concurrently -> all four outputs valid in the same cycle.
- Mid-traffic reset: ARESETn low for 1 cycle during streaming -> all outputs 0 immediately; no stale flit after release.
